// File: rtl/bcd_scan_display.sv
// Binary to multi-digit BCD (serial double-dabble) with a scanned 7-segment output.
// Define BCD_BLANK_EN to blank leading zero digits.
module bcd_scan_display #(
   parameter int WIDTH       = 8,
   parameter int DIGITS      = 3,
   parameter int REFRESH_DIV = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WIDTH-1:0]  bin,
   output logic              busy,
   output logic              done,
   output logic              ovf,
   output logic [6:0]        seg,
   output logic [DIGITS-1:0] an
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

   state_t          state, state_nx;
   logic [WIDTH-1:0] sr;
   logic [BW-1:0]   bcd, adj, disp;
   logic            sticky;
   logic [CW-1:0]   cnt;
   logic            last;
   logic [PW-1:0]   pre;
   logic [IW-1:0]   idx;
   logic [3:0]      dig;
   logic [6:0]      dec, seg_nx;

   assign last = (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = CONV;
         CONV:    if (last)  state_nx = LOAD;
         LOAD:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state)
         CONV:    busy = 1'b1;
         LOAD:    begin busy = 1'b1; done = 1'b1; end
         default: ;
      endcase
   end

   always_comb begin
      adj = bcd;
      for (int d = 0; d < DIGITS; d++)
         if (bcd[4*d +: 4] >= 4'd5) adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
   end

   // The bit shifted out of the top nibble would start a digit we do not have.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr     <= '0;
         bcd    <= '0;
         sticky <= 1'b0;
         cnt    <= '0;
         disp   <= '0;
         ovf    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: if (start) begin
               sr     <= bin;
               bcd    <= '0;
               sticky <= 1'b0;
               cnt    <= '0;
            end
            CONV: begin
               sr     <= {sr[WIDTH-2:0], 1'b0};
               bcd    <= {adj[BW-2:0], sr[WIDTH-1]};
               sticky <= sticky | adj[BW-1];
               cnt    <= cnt + CW'(1);
            end
            LOAD: begin
               disp <= bcd;
               ovf  <= sticky;
            end
            default: ;
         endcase
      end
   end

   assign dig = disp[{idx, 2'b00} +: 4];

   always_comb begin
      case (dig)
         4'd0:    dec = 7'h7E;
         4'd1:    dec = 7'h30;
         4'd2:    dec = 7'h6D;
         4'd3:    dec = 7'h79;
         4'd4:    dec = 7'h33;
         4'd5:    dec = 7'h5B;
         4'd6:    dec = 7'h5F;
         4'd7:    dec = 7'h70;
         4'd8:    dec = 7'h7F;
         4'd9:    dec = 7'h7B;
         default: dec = 7'h00;
      endcase
   end

`ifdef BCD_BLANK_EN
   logic zero_hi, blank;

   always_comb begin
      zero_hi = 1'b1;
      blank   = 1'b0;
      for (int j = DIGITS - 1; j >= 1; j--) begin
         zero_hi = zero_hi & (disp[4*j +: 4] == 4'd0);
         if (idx == IW'(j)) blank = zero_hi;
      end
      seg_nx = (blank && !ovf) ? 7'h00 : dec;
   end
`else
   assign seg_nx = dec;
`endif

   // seg and an share one register stage so they always switch together.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre <= '0;
         idx <= '0;
         seg <= 7'h7E;
         an  <= ~DIGITS'(1);
      end else begin
         if (pre == PW'(REFRESH_DIV - 1)) begin
            pre <= '0;
            idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
         end else begin
            pre <= pre + PW'(1);
         end
         seg <= seg_nx;
         an  <= ~(DIGITS'(1) << idx);
      end
   end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display: two instances (8b/3 digits/div 4
// and 8b/2 digits/div 1), a monitor per instance checks done timing and digits.
module tb_bcd_scan_display;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst0, rst1, start0, start1;
   logic [7:0] bin0, bin1;
   logic       busy0, done0, ovf0, busy1, done1, ovf1;
   logic [6:0] seg0, seg1;
   logic [2:0] an0;
   logic [1:0] an1;

   bcd_scan_display #(.WIDTH(8), .DIGITS(3), .REFRESH_DIV(4)) u0 (
      .clk(clk), .rst(rst0), .start(start0), .bin(bin0),
      .busy(busy0), .done(done0), .ovf(ovf0), .seg(seg0), .an(an0)
   );

   bcd_scan_display #(.WIDTH(8), .DIGITS(2), .REFRESH_DIV(1)) u1 (
      .clk(clk), .rst(rst1), .start(start1), .bin(bin1),
      .busy(busy1), .done(done1), .ovf(ovf1), .seg(seg1), .an(an1)
   );

   typedef struct {
      int          acc;
      logic [31:0] dig;
      logic        ovf;
   } item_t;

   item_t q0[$];
   item_t q1[$];
   int    errs = 0;
   int    checks = 0;
   int    cyc = 0;
   bit    mon_act[2];
   logic  prev_ovf[2];

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic get_done(int u);
      return (u != 0) ? done1 : done0;
   endfunction
   function automatic logic get_busy(int u);
      return (u != 0) ? busy1 : busy0;
   endfunction
   function automatic logic get_ovf(int u);
      return (u != 0) ? ovf1 : ovf0;
   endfunction
   function automatic logic [6:0] get_seg(int u);
      return (u != 0) ? seg1 : seg0;
   endfunction
   function automatic logic [2:0] get_an(int u);
      return (u != 0) ? {1'b1, an1} : an0;
   endfunction
   function automatic int qsize(int u);
      return (u != 0) ? q1.size() : q0.size();
   endfunction

   function automatic logic [6:0] segof(logic [3:0] d);
      case (d)
         4'd0: return 7'h7E;
         4'd1: return 7'h30;
         4'd2: return 7'h6D;
         4'd3: return 7'h79;
         4'd4: return 7'h33;
         4'd5: return 7'h5B;
         4'd6: return 7'h5F;
         4'd7: return 7'h70;
         4'd8: return 7'h7F;
         4'd9: return 7'h7B;
         default: return 7'h00;
      endcase
   endfunction

   function automatic logic [6:0] exp_seg(logic [31:0] dig, logic ov,
                                          int i, int nd);
      logic [6:0] s;
`ifdef BCD_BLANK_EN
      logic z;
`endif
      s = segof(dig[4*i +: 4]);
`ifdef BCD_BLANK_EN
      if (!ov && i > 0) begin
         z = 1'b1;
         for (int j = i; j < nd; j++)
            if (dig[4*j +: 4] != 4'd0) z = 1'b0;
         if (z) s = 7'h00;
      end
`else
      if (ov && nd < 0) s = 7'h00;
`endif
      return s;
   endfunction

   function automatic logic [2:0] an_next(logic [2:0] a);
      case (a)
         3'b110:  return 3'b101;
         3'b101:  return 3'b011;
         3'b011:  return 3'b110;
         default: return 3'b000;
      endcase
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d",
                  name, act, exp, cyc);
      end
   endtask

   task automatic scan_chk(int u, logic [31:0] dig, logic ov, string tag);
      int         nd, rd;
      logic [6:0] got[3];
      bit         seen[3];
      logic [2:0] m;
      nd = (u != 0) ? 2 : 3;
      rd = (u != 0) ? 1 : 4;
      for (int i = 0; i < 3; i++) begin
         seen[i] = 1'b0;
         got[i]  = 7'h00;
      end
      for (int n = 0; n < nd * rd; n++) begin
         @(negedge clk);
         for (int i = 0; i < nd; i++) begin
            m = ~(3'd1 << i);
            if (get_an(u) == m) begin
               got[i]  = get_seg(u);
               seen[i] = 1'b1;
            end
         end
      end
      for (int i = 0; i < nd; i++) begin
         chk($sformatf("%s_u%0d_seen%0d", tag, u, i), 32'(seen[i]), 32'd1);
         chk($sformatf("%s_u%0d_seg%0d", tag, u, i), 32'(got[i]),
             32'(exp_seg(dig, ov, i, nd)));
      end
   endtask

   task automatic mon(int u);
      item_t it;
      forever begin
         @(negedge clk);
         if (get_done(u)) begin
            mon_act[u] = 1'b1;
            if (qsize(u) == 0) begin
               checks++;
               errs++;
               $display("FAIL unexpected_done u%0d at cycle %0d", u, cyc);
            end else begin
               it = (u != 0) ? q1.pop_front() : q0.pop_front();
               chk($sformatf("done_time_u%0d", u), cyc, it.acc + 8);
               chk($sformatf("ovf_held_u%0d", u), 32'(get_ovf(u)),
                   32'(prev_ovf[u]));
               @(negedge clk);
               chk($sformatf("done_pulse_u%0d", u), 32'(get_done(u)), 32'd0);
               chk($sformatf("ovf_u%0d", u), 32'(get_ovf(u)), 32'(it.ovf));
               prev_ovf[u] = it.ovf;
               @(posedge clk);
               scan_chk(u, it.dig, it.ovf, "disp");
            end
            mon_act[u] = 1'b0;
         end
      end
   endtask

   task automatic push(int u, int acc, logic [31:0] dig, logic ov);
      item_t it;
      it.acc = acc;
      it.dig = dig;
      it.ovf = ov;
      if (u != 0) q1.push_back(it);
      else        q0.push_back(it);
   endtask

   task automatic wait_idle(int u);
      for (int t = 0; t < 300; t++) begin
         @(negedge clk);
         if (!get_busy(u) && !mon_act[u] && qsize(u) == 0) return;
      end
      checks++;
      errs++;
      $display("FAIL idle_timeout u%0d at cycle %0d", u, cyc);
   endtask

   task automatic go(int u, logic [7:0] b, logic [31:0] dig, logic ov);
      wait_idle(u);
      @(negedge clk);
      push(u, cyc + 1, dig, ov);
      if (u != 0) begin start1 = 1'b1; bin1 = b; end
      else        begin start0 = 1'b1; bin0 = b; end
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
   endtask

   initial begin
      int         a, run, nruns;
      logic [2:0] pa;
      rst0 = 1'b1; rst1 = 1'b1;
      start0 = 1'b0; start1 = 1'b0;
      bin0 = '0; bin1 = '0;
      mon_act[0] = 1'b0; mon_act[1] = 1'b0;
      prev_ovf[0] = 1'b0; prev_ovf[1] = 1'b0;
      fork
         mon(0);
         mon(1);
      join_none
      repeat (2) @(negedge clk);
      rst0 = 1'b0; rst1 = 1'b0;

      // reset in the middle of the scan
      repeat (7) @(negedge clk);
      rst0 = 1'b1;
      repeat (2) @(negedge clk);
      rst0 = 1'b0;
      @(negedge clk);
      chk("rst_seg", 32'(seg0), 32'h7E);
      chk("rst_an", 32'(an0), 32'b110);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_ovf", 32'(ovf0), 32'd0);

      go(0, 8'd255, 32'h255, 1'b0);
      go(0, 8'd7, 32'h007, 1'b0);

      // scan order and dwell time
      wait_idle(0);
      pa = an0;
      run = 1;
      nruns = 0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (an0 == pa) begin
            run++;
         end else begin
            chk("an_next", 32'(an0), 32'(an_next(pa)));
            if (nruns > 0) chk("an_dwell", run, 4);
            nruns++;
            pa = an0;
            run = 1;
         end
      end
      chk("an_runs", 32'(nruns >= 6), 32'd1);

      // reset after three iterations discards the conversion
      wait_idle(0);
      @(negedge clk);
      start0 = 1'b1;
      bin0 = 8'd200;
      @(negedge clk);
      start0 = 1'b0;
      repeat (3) @(negedge clk);
      chk("midconv_busy", 32'(busy0), 32'd1);
      rst0 = 1'b1;
      repeat (2) @(negedge clk);
      rst0 = 1'b0;
      chk("post_rst_busy", 32'(busy0), 32'd0);
      scan_chk(0, 32'h000, 1'b0, "post_rst");
      prev_ovf[0] = 1'b0;
      go(0, 8'd42, 32'h042, 1'b0);

      go(1, 8'd255, 32'h55, 1'b1);
      go(1, 8'd99, 32'h99, 1'b0);

      // start pulse while busy is ignored
      wait_idle(1);
      @(negedge clk);
      push(1, cyc + 1, 32'h37, 1'b0);
      start1 = 1'b1;
      bin1 = 8'd37;
      @(negedge clk);
      start1 = 1'b0;
      repeat (3) @(negedge clk);
      start1 = 1'b1;
      bin1 = 8'd200;
      @(negedge clk);
      start1 = 1'b0;

      // start held high: back-to-back conversions
      wait_idle(1);
      @(negedge clk);
      a = cyc + 1;
      push(1, a, 32'h55, 1'b1);
      push(1, a + 10, 32'h99, 1'b0);
      push(1, a + 20, 32'h10, 1'b0);
      start1 = 1'b1;
      bin1 = 8'd255;
      @(negedge clk);
      bin1 = 8'd99;
      while (cyc < a + 10) @(negedge clk);
      bin1 = 8'd10;
      while (cyc < a + 20) @(negedge clk);
      start1 = 1'b0;

      wait_idle(0);
      wait_idle(1);
      repeat (4) @(negedge clk);
      chk("q0_empty", 32'(q0.size()), 32'd0);
      chk("q1_empty", 32'(q1.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Parametrised binary-to-multi-digit 7-segment display driver. It converts a WIDTH-bit unsigned binary value to DIGITS BCD digits with a sequential double-dabble engine, one shift per clock. It then time-multiplexes the digits onto a shared segment bus with per-digit enables. It sits between datapath result registers and the board's multiplexed 7-segment display, and replaces the single-digit combinational decoder.

## Interface
- WIDTH, 8: binary input width; legal range 4..32.
- DIGITS, 3: number of BCD digits and display positions; legal range 1..8.
- REFRESH_DIV, 1000: clock cycles each digit stays lit; minimum 1.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  WIDTH  unsigned value; captured on the edge that accepts start.
- busy  output  1  high in CONV and LOAD.
- done  output  1  high for exactly one cycle, in LOAD.
- ovf  output  1  the displayed value did not fit in DIGITS digits.
- seg  output  7  segments {a,b,c,d,e,f,g}, MSB = a; active-high.
- an  output  DIGITS  digit enables; one-hot, active-low; an[0] is the least-significant digit.

## Operation
- The FSM has three states: IDLE, CONV and LOAD.
- IDLE with start=1: on that edge, capture bin into a shift register and clear the BCD register (4*DIGITS bits), the overflow sticky and the bit counter. Go to CONV.
- CONV: each cycle performs one double-dabble iteration.
  - Add 3 to every BCD nibble that is >= 5.
  - Shift {BCD, bin} left by 1; the bin MSB enters the BCD LSB.
  - If a 1 leaves the BCD MSB, set the overflow sticky.
  - After WIDTH iterations, go to LOAD.
- LOAD: done=1. On the edge leaving LOAD:
  - copy the BCD register into the display registers;
  - copy the overflow sticky into ovf;
  - go to IDLE.
- start is ignored while busy=1; no queuing.
- The display registers and ovf keep their previous value throughout CONV and LOAD, so the display never shows intermediate values.
- Scan:
  - The prescaler counts 0..REFRESH_DIV-1. On wrap, the digit index advances and wraps from DIGITS-1 to 0.
  - an[idx]=0 and all other an bits are 1.
  - seg is the decode of display digit idx: 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B (hex).
  - Nibble values 10..15 cannot occur and decode to 00.
- When ovf=1, the display shows the low DIGITS digits of the true value.
- The scan runs continuously and independently of the FSM.

## Timing
- Start accepted on edge k:
  - CONV occupies cycles k+1..k+WIDTH.
  - LOAD (done=1) is cycle k+WIDTH+1.
  - New digits and ovf are visible from cycle k+WIDTH+2.
- Conversion latency is WIDTH+1 cycles from the accepting edge to done.
- Back-to-back: start held high through LOAD is accepted on the first IDLE edge, k+WIDTH+2. Each conversion therefore occupies WIDTH+2 cycles.
- seg and an are registered. They change one cycle after the prescaler wrap edge, and both change on the same edge, so no stale-digit glitch occurs.
- Reset values, at any time including mid-conversion:
  - state=IDLE, busy=0, done=0, ovf=0;
  - display registers all 0;
  - prescaler 0, idx 0;
  - an = all ones except an[0]=0;
  - seg = 7E.
- An in-flight conversion is discarded on reset and produces no done pulse.
- REFRESH_DIV=1: the digit advances every cycle.
- DIGITS=1: an stays 0 permanently.

## Configuration
- BCD_BLANK_EN defined: leading-zero blanking. A digit with index > 0 outputs seg=00 when it and all higher digits are 0; digit 0 is never blanked.
  - This is evaluated on the display registers, registered with seg.
  - When ovf=1, blanking is disabled and all digits are shown.
- BCD_BLANK_EN undefined: every digit is always shown, including leading zeros.

## Test plan
- Reset: assert rst for 2 cycles mid-scan -> seg=7E, an[0]=0, busy=0, done=0, ovf=0 on the following cycle.
- Conversion, WIDTH=8, DIGITS=3: bin=255 with a start pulse -> done exactly 9 cycles after the accepting edge. The scan then shows digit0=5 (5B), digit1=5 (5B), digit2=2 (6D), with ovf=0.
- Overflow, WIDTH=8, DIGITS=2: bin=255 -> ovf=1 and digits 5,5. Then bin=99 -> ovf=0 and digits 9,9 (7B, 7B).
- Handshake: a start pulse during CONV, and start held high continuously:
  - the busy-time pulse is ignored;
  - with start held high, conversions are spaced WIDTH+2 cycles apart;
  - the display does not change before LOAD+1.
- Reset mid-CONV after 3 iterations -> no done; display returns to 0; a subsequent start with bin=42 gives 0,4,2.
- Scan, REFRESH_DIV=4, DIGITS=3, value 7:
  - an cycles 110 -> 101 -> 011 (an[2:0]), each for 4 cycles;
  - with BCD_BLANK_EN, the segments are 70, 00, 00;
  - without BCD_BLANK_EN, the segments are 70, 7E, 7E.
